reg_file: RTL and testbench

- Register file of NREG word registers that consumes the team's 2-bit funsel encoding (clear/load/decrement/increment) and sits directly downstream of the single-register stage.
- Each register is a clocked cell with enable. A one-hot-capable select mask chooses which registers act each cycle.
- Two independent read ports feed the ALU A and B operands.
- Fully synchronous to one clock, with asynchronous active-low reset.

---
 rtl/reg_pkg.sv | 13 +
 rtl/reg_cell.sv | 51 +++++
 rtl/reg_file.sv | 44 ++++
 tb/tb_reg_file.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/reg_pkg.sv
// Shared funsel encoding used by every register-based block.
package reg_pkg;

    typedef enum logic [1:0] {
        FS_CLR = 2'b00,
        FS_LD  = 2'b01,
        FS_DEC = 2'b10,
        FS_INC = 2'b11
    } funsel_t;

    localparam int unsigned FUNSEL_W = 2;

endpackage : reg_pkg

// File: rtl/reg_cell.sv
// One register with enable: clear/load/decrement/increment plus a registered wrap pulse.
module reg_cell
    import reg_pkg::*;
#(
    parameter int unsigned NBITS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       funsel,
    input  logic [NBITS-1:0] i,
    output logic [NBITS-1:0] q,
    output logic             wrap
);

    logic [NBITS-1:0] q_nxt_c;
    logic             wrap_nxt_c;

    // Next-state mux and wrap detection; an unrecognised funsel holds the value.
    always_comb begin
        q_nxt_c    = q;
        wrap_nxt_c = 1'b0;
        case (funsel)
            FS_CLR: q_nxt_c = '0;
            FS_LD:  q_nxt_c = i;
            FS_DEC: begin
                q_nxt_c    = q - NBITS'(1);
                wrap_nxt_c = (q == '0);
            end
            FS_INC: begin
                q_nxt_c    = q + NBITS'(1);
                wrap_nxt_c = (q == '1);
            end
            default: q_nxt_c = q;
        endcase
    end

    // Storage is touched only when enabled, so a known-0 enable shields it from X controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= en & wrap_nxt_c;
            if (en) begin
                q <= q_nxt_c;
            end
        end
    end

endmodule : reg_cell

// File: rtl/reg_file.sv
// NREG-entry register file driven by a select mask, with two combinational read ports.
module reg_file
    import reg_pkg::*;
#(
    parameter  int unsigned NBITS = 16,
    parameter  int unsigned NREG  = 8,
    localparam int unsigned SELW  = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NBITS-1:0] i,
    input  logic [1:0]       funsel,
    input  logic [NREG-1:0]  regsel,
    input  logic [SELW-1:0]  out_a_sel,
    input  logic [SELW-1:0]  out_b_sel,
    output logic [NBITS-1:0] out_a,
    output logic [NBITS-1:0] out_b,
    output logic [NREG-1:0]  wrap,
    output logic [NREG-1:0]  zero
);

    logic [NBITS-1:0] regs [NREG];

    for (genvar k = 0; k < NREG; k++) begin : g_cell
        reg_cell #(
            .NBITS (NBITS)
        ) u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (regsel[k]),
            .funsel (funsel),
            .i      (i),
            .q      (regs[k]),
            .wrap   (wrap[k])
        );

        assign zero[k] = (regs[k] == '0);
    end

    // NREG is a power of two, so every select value addresses a real register.
    assign out_a = regs[out_a_sel];
    assign out_b = regs[out_b_sel];

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed bench for reg_file with hand-computed expectations.
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic [15:0] i;
    logic [1:0]  funsel;
    logic [7:0]  regsel;
    logic [2:0]  out_a_sel;
    logic [2:0]  out_b_sel;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic [7:0]  wrap;
    logic [7:0]  zero;

    int checks   = 0;
    int failures = 0;

    reg_file #(
        .NBITS (16),
        .NREG  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i         (i),
        .funsel    (funsel),
        .regsel    (regsel),
        .out_a_sel (out_a_sel),
        .out_b_sel (out_b_sel),
        .out_a     (out_a),
        .out_b     (out_b),
        .wrap      (wrap),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one operation for exactly one rising edge; returns 1 time unit after that edge.
    task automatic op(input logic [7:0] sel, input logic [1:0] fs, input logic [15:0] d);
        @(negedge clk);
        regsel = sel;
        funsel = fs;
        i      = d;
        @(posedge clk);
        #1;
        regsel = 8'h00;
    endtask

    initial begin
        rst_n     = 1'b0;
        i         = 16'h0000;
        funsel    = 2'b00;
        regsel    = 8'h00;
        out_a_sel = 3'd0;
        out_b_sel = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_zero", 32'(zero), 32'h00FF);
        chk("reset_wrap", 32'(wrap), 32'h0000);
        chk("reset_out_a", 32'(out_a), 32'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Load two registers at once
        op(8'h05, 2'b01, 16'hABCD);
        out_a_sel = 3'd0;
        out_b_sel = 3'd2;
        #1;
        chk("load_out_a", 32'(out_a), 32'hABCD);
        chk("load_out_b", 32'(out_b), 32'hABCD);
        chk("load_zero", 32'(zero), 32'h00FA);
        chk("load_wrap", 32'(wrap), 32'h0000);
        out_a_sel = 3'd1;
        #1;
        chk("load_r1_held", 32'(out_a), 32'h0000);

        // Increment wrap on R7
        op(8'h80, 2'b01, 16'hFFFF);
        chk("ld_r7_zero", 32'(zero), 32'h007A);
        chk("ld_r7_wrap", 32'(wrap), 32'h0000);
        op(8'h80, 2'b11, 16'h0000);
        out_a_sel = 3'd7;
        #1;
        chk("inc_wrap_r7", 32'(out_a), 32'h0000);
        chk("inc_wrap_pulse", 32'(wrap), 32'h0080);
        chk("inc_wrap_zero", 32'(zero), 32'h00FA);
        op(8'h00, 2'b11, 16'h0000);
        chk("inc_wrap_clear", 32'(wrap), 32'h0000);

        // Decrement wrap on R4
        op(8'h10, 2'b10, 16'h0000);
        out_a_sel = 3'd4;
        #1;
        chk("dec_wrap_r4", 32'(out_a), 32'hFFFF);
        chk("dec_wrap_pulse", 32'(wrap), 32'h0010);
        chk("dec_wrap_zero", 32'(zero), 32'h00EA);
        op(8'h00, 2'b10, 16'h0000);
        chk("noop_wrap", 32'(wrap), 32'h0000);
        chk("noop_r4_held", 32'(out_a), 32'hFFFF);

        // Mixed multi-select increment
        op(8'h01, 2'b01, 16'h0005);
        op(8'h02, 2'b01, 16'hFFFF);
        op(8'h03, 2'b11, 16'h0000);
        out_a_sel = 3'd0;
        out_b_sel = 3'd1;
        #1;
        chk("multi_r0", 32'(out_a), 32'h0006);
        chk("multi_r1", 32'(out_b), 32'h0000);
        chk("multi_wrap", 32'(wrap), 32'h0002);
        chk("multi_zero", 32'(zero), 32'h00EA);

        // Multi clear, then a non-wrapping decrement
        op(8'h05, 2'b00, 16'h0000);
        chk("clr_zero", 32'(zero), 32'h00EF);
        chk("clr_wrap", 32'(wrap), 32'h0000);
        op(8'h10, 2'b10, 16'h0000);
        out_a_sel = 3'd4;
        #1;
        chk("dec_r4", 32'(out_a), 32'hFFFE);
        chk("dec_nowrap", 32'(wrap), 32'h0000);

        // Same-cycle read returns the pre-edge value
        @(negedge clk);
        out_a_sel = 3'd0;
        out_b_sel = 3'd0;
        regsel    = 8'h01;
        funsel    = 2'b01;
        i         = 16'h0042;
        #1;
        chk("bypass_pre_a", 32'(out_a), 32'h0000);
        chk("bypass_pre_b", 32'(out_b), 32'h0000);
        @(posedge clk);
        #1;
        regsel = 8'h00;
        chk("bypass_post_a", 32'(out_a), 32'h0042);
        chk("bypass_post_b", 32'(out_b), 32'h0042);

        // Asynchronous reset mid-run with a wrap pulse live
        op(8'h08, 2'b01, 16'h1234);
        out_a_sel = 3'd3;
        #1;
        chk("pre_rst_r3", 32'(out_a), 32'h1234);
        op(8'h80, 2'b01, 16'hFFFF);
        op(8'h80, 2'b11, 16'h0000);
        chk("pre_rst_wrap", 32'(wrap), 32'h0080);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_r3", 32'(out_a), 32'h0000);
        chk("rst_async_zero", 32'(zero), 32'h00FF);
        chk("rst_async_wrap", 32'(wrap), 32'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        op(8'h02, 2'b01, 16'h0007);
        out_a_sel = 3'd1;
        #1;
        chk("post_rst_load", 32'(out_a), 32'h0007);
        chk("post_rst_zero", 32'(zero), 32'h00FD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_reg_file
